// File: rtl/sample_chan_arbiter.sv
// -----------------------------------------------------------------------------
// sample_chan_arbiter
//
// Merges NREQ valid-only producer channels onto one shared valid/ready
// consumer channel. Producers have no backpressure, so each owns a private
// FIFO of DEPTH entries. A round-robin scheduler drains the FIFOs into a
// registered output stage. A beat that arrives at a full FIFO that is not
// being popped on the same edge is dropped, and that requester's sticky
// overflow flag is raised.
//
// Handshake: out_valid/out_data/out_src describe one beat. The beat transfers
// on a rising edge where out_valid && out_ready. Once out_valid is high, the
// stage holds out_valid, out_data and out_src stable until that transfer
// happens. The stage reloads whenever it is empty or being drained.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   per-requester valid (bit i qualifies slice i of in_data)
//   in_data    packed requester data, slice i = in_data[i*WIDTH +: WIDTH]
//   out_valid  output stage holds a beat
//   out_ready  sink accepts the beat
//   out_data   granted data
//   out_src    index of the requester that produced out_data
//   ovf        sticky per-requester overflow (a beat was dropped)
//   clr_ovf    clears ovf bits that are not being set on the same edge
// -----------------------------------------------------------------------------
module sample_chan_arbiter #(
  parameter  int NREQ  = 3,
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       in_valid,
  input  logic [NREQ*WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SRC_W-1:0]      out_src,
  output logic [NREQ-1:0]       ovf,
  input  logic                  clr_ovf
);

  // The address is the low AW pointer bits. The extra top bit is the wrap
  // bit: pointers are equal means empty, and pointers that differ only in the
  // wrap bit mean full.
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  // ---------------------------------------------------------------------------
  // Per-requester FIFO state
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem       [NREQ][DEPTH];
  logic [PTR_W-1:0] wr_ptr    [NREQ];
  logic [PTR_W-1:0] rd_ptr    [NREQ];
  logic [WIDTH-1:0] head_data [NREQ];

  logic [NREQ-1:0]  fifo_empty;
  logic [NREQ-1:0]  fifo_full;
  logic [NREQ-1:0]  pop;
  logic [NREQ-1:0]  push;
  logic [NREQ-1:0]  ovf_set;

  // Round-robin pointer: the index granted most recently. The search starts
  // one past it.
  logic [SRC_W-1:0] rr;

  // Scheduler signals
  logic             load;
  logic             grant_valid;
  logic [SRC_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
      fifo_full[i]  = (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]) &&
                      (wr_ptr[i][AW]     != rd_ptr[i][AW]);
      head_data[i]  = mem[i][rd_ptr[i][AW-1:0]];
    end
  end

  // The output stage can take a new beat when it is empty or when its
  // current beat leaves on this edge.
  assign load = !out_valid || out_ready;

  // Pick the first non-empty FIFO, searching from rr+1 and wrapping modulo
  // NREQ. The search checks rr itself last, so a requester waits at most
  // NREQ-1 grants.
  always_comb begin
    int cand;
    cand        = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(rr) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!grant_valid && !fifo_empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(cand);
      end
    end
  end

  assign grant_data = head_data[grant_idx];

  // A full FIFO still accepts a write if its head is popped on the same
  // edge. The write lands in the slot being freed, and the read of that slot
  // uses the value from before the edge.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      pop[i]     = load && grant_valid && (grant_idx == SRC_W'(i));
      push[i]    = in_valid[i] && (!fifo_full[i] || pop[i]);
      ovf_set[i] = in_valid[i] && fifo_full[i] && !pop[i];
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers (reset discards every queued beat)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
      end
    end
  end

  // The storage array needs no reset because the pointers decide which
  // entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i][AW-1:0]] <= in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered output stage, round-robin pointer and sticky overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      // Start at NREQ-1 so that the first search after reset begins at
      // requester 0.
      rr        <= SRC_W'(NREQ - 1);
      ovf       <= '0;
    end else begin
      if (load) begin
        if (grant_valid) begin
          out_valid <= 1'b1;
          out_data  <= grant_data;
          out_src   <= grant_idx;
          rr        <= grant_idx;
        end else begin
          // When no FIFO has data, drop valid. out_data and out_src keep
          // their old values.
          out_valid <= 1'b0;
        end
      end
      // A bit being set on this edge wins over clr_ovf.
      ovf <= ovf_set | (ovf & ~{NREQ{clr_ovf}});
    end
  end

endmodule
